// File: rtl/assoc_wb_cache_if.sv
// Core request/response and word-serial memory bundle of the cache.
// master drives requests and memory replies; slave is the cache itself.
interface assoc_wb_cache_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output mem_rdata, mem_ack,
        input  req_ready, resp_valid, resp_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  mem_rdata, mem_ack,
        output req_ready, resp_valid, resp_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/assoc_wb_cache.sv
// N-way set-associative write-back/write-allocate cache, true-LRU,
// multi-word lines, word-serial memory side with ack handshake.
module assoc_wb_cache #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    assoc_wb_cache_if.slave bus,
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count
);
    localparam int IDX_W   = $clog2(SETS);
    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int WRD_W   = (OFF_W > 0) ? OFF_W : 1;
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_LSB = IDX_W + OFF_W + 2;
    localparam int TAG_W   = ADDR_W - TAG_LSB;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESP
    } state_t;

    state_t            r_state;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_rdata;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [WRD_W-1:0]  r_cnt;
    logic [WAY_W-1:0]  r_vway;
    logic [31:0]       r_hits;
    logic [31:0]       r_misses;

    logic [DATA_W-1:0] r_data  [WAYS][SETS][LINE_WORDS];
    logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
    logic [SETS-1:0]   r_valid [WAYS];
    logic [SETS-1:0]   r_dirty [WAYS];
    logic [WAY_W-1:0]  r_age   [WAYS][SETS];

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [WRD_W-1:0]  w_word;
    logic [WRD_W-1:0]  w_cnt_nx;
    logic              w_ack;
    logic              w_last;
    logic              w_hit;
    logic              w_vdirty;
    logic [WAY_W-1:0]  w_hway;
    logic [WAY_W-1:0]  w_vway;
    logic [WAY_W-1:0]  w_away;
    logic [WAY_W-1:0]  w_oage;
    logic [WAY_W-1:0]  w_nage [WAYS];
    logic              w_unused;

    assign w_idx    = r_addr[OFF_W+2 +: IDX_W];
    assign w_tag    = r_addr[TAG_LSB +: TAG_W];
    assign w_word   = WRD_W'((r_addr >> 2) & ADDR_W'(LINE_WORDS - 1));
    assign w_cnt_nx = r_cnt + 1'b1;
    assign w_ack    = bus.mem_ack && r_mem_req;
    assign w_last   = (r_cnt == WRD_W'(LINE_WORDS - 1));
    assign w_vdirty = r_valid[w_vway][w_idx] && r_dirty[w_vway][w_idx];
    assign w_unused = ^r_addr[1:0];

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_rdata;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign hit_count      = r_hits;
    assign miss_count     = r_misses;

    function automatic logic [ADDR_W-1:0] mk_addr(
        input logic [TAG_W-1:0] t,
        input logic [IDX_W-1:0] s,
        input logic [WRD_W-1:0] c
    );
        mk_addr = (ADDR_W'(t) << TAG_LSB) |
                  (ADDR_W'(s) << (OFF_W + 2)) |
                  (ADDR_W'(c) << 2);
    endfunction

    // Victim: lowest invalid way wins, else the oldest (ties -> lowest).
    always_comb begin
        w_hit  = 1'b0;
        w_hway = '0;
        w_vway = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
                w_hit  = 1'b1;
                w_hway = WAY_W'(w);
            end
            if (r_age[w][w_idx] > r_age[w_vway][w_idx])
                w_vway = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--)
            if (!r_valid[w][w_idx])
                w_vway = WAY_W'(w);
    end

    // An invalid way counts as oldest so every valid way ages on its fill.
    always_comb begin
        w_away = (r_state == S_LOOKUP) ? w_hway : r_vway;
        w_oage = r_valid[w_away][w_idx] ? r_age[w_away][w_idx]
                                        : WAY_W'(WAYS - 1);
        for (int w = 0; w < WAYS; w++) begin
            w_nage[w] = r_age[w][w_idx];
            if (WAY_W'(w) == w_away)
                w_nage[w] = '0;
            else if (r_valid[w][w_idx] && r_age[w][w_idx] < w_oage)
                w_nage[w] = r_age[w][w_idx] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_LOOKUP && w_hit && r_we)
            r_data[w_hway][w_idx][w_word] <= r_wdata;
        if (r_state == S_FILL && w_ack) begin
            r_data[r_vway][w_idx][r_cnt] <=
                (r_we && r_cnt == w_word) ? r_wdata : bus.mem_rdata;
            if (w_last)
                r_tag[r_vway][w_idx] <= w_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_vway       <= '0;
            r_hits       <= '0;
            r_misses     <= '0;
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
                r_dirty[w] <= '0;
                for (int s = 0; s < SETS; s++)
                    r_age[w][s] <= '0;
            end
        end else begin
            r_resp_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_addr      <= bus.req_addr;
                        r_we        <= bus.req_we;
                        r_wdata     <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        r_state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_cnt  <= '0;
                    r_vway <= w_vway;
                    if (w_hit) begin
                        if (r_hits != '1)
                            r_hits <= r_hits + 1'b1;
                        if (r_we)
                            r_dirty[w_hway][w_idx] <= 1'b1;
                        r_rdata <= r_we ? r_wdata
                                        : r_data[w_hway][w_idx][w_word];
                        for (int w = 0; w < WAYS; w++)
                            r_age[w][w_idx] <= w_nage[w];
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        if (r_misses != '1)
                            r_misses <= r_misses + 1'b1;
                        r_mem_req <= 1'b1;
                        if (w_vdirty) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= mk_addr(r_tag[w_vway][w_idx],
                                                   w_idx, WRD_W'(0));
                            r_mem_wdata <= r_data[w_vway][w_idx][0];
                            r_state     <= S_WB;
                        end else begin
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= mk_addr(w_tag, w_idx, WRD_W'(0));
                            r_state    <= S_FILL;
                        end
                    end
                end
                S_WB: begin
                    if (w_ack) begin
                        if (w_last) begin
                            r_cnt      <= '0;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= mk_addr(w_tag, w_idx, WRD_W'(0));
                            r_state    <= S_FILL;
                        end else begin
                            r_cnt       <= w_cnt_nx;
                            r_mem_addr  <= mk_addr(r_tag[r_vway][w_idx],
                                                   w_idx, w_cnt_nx);
                            r_mem_wdata <= r_data[r_vway][w_idx][w_cnt_nx];
                        end
                    end
                end
                S_FILL: begin
                    if (w_ack) begin
                        if (r_cnt == w_word)
                            r_rdata <= r_we ? r_wdata : bus.mem_rdata;
                        if (w_last) begin
                            r_mem_req              <= 1'b0;
                            r_valid[r_vway][w_idx] <= 1'b1;
                            r_dirty[r_vway][w_idx] <= r_we;
                            for (int w = 0; w < WAYS; w++)
                                r_age[w][w_idx] <= w_nage[w];
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            r_cnt      <= w_cnt_nx;
                            r_mem_addr <= mk_addr(w_tag, w_idx, w_cnt_nx);
                        end
                    end
                end
                S_RESP: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_assoc_wb_cache.sv
// Scoreboard bench for assoc_wb_cache: 2 ways, 4 sets, 4-word lines,
// memory model returning mem[a]=a with random ack latency.
module tb_assoc_wb_cache;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    assoc_wb_cache_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    assoc_wb_cache #(
        .ADDR_W(32), .DATA_W(32), .WAYS(2), .SETS(4), .LINE_WORDS(4)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .bus        (bus.slave),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    xfer_t       xq[$];
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] mem_model [logic [31:0]];
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_ack = 0;
    bit          hold_ack = 1'b0;
    int          fixed_dly = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : a;
    endfunction

    task automatic exp_fill(input logic [31:0] base);
        for (int i = 0; i < 4; i++)
            xq.push_back('{we: 1'b0, addr: base + 32'(4 * i), data: 32'h0});
    endtask

    task automatic exp_wb(input logic [31:0] base);
        for (int i = 0; i < 4; i++)
            xq.push_back('{we: 1'b1, addr: base + 32'(4 * i),
                           data: ref_rd(base + 32'(4 * i))});
    endtask

    // Memory responder: checks each acked transfer against the expected queue.
    initial begin
        int    dly;
        xfer_t x;
        dly = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (!bus.mem_req || !rst_b) dly = 0;
            else if (!hold_ack) begin
                if (dly == 0)
                    dly = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 5));
                dly--;
                if (dly == 0) begin
                    bus.mem_ack = 1'b1;
                    n_ack++;
                    if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = mem_model.exists(bus.mem_addr) ?
                                         mem_model[bus.mem_addr] : bus.mem_addr;
                    if (xq.size() == 0)
                        check("xfer_unexpected", bus.mem_addr, 32'hFFFF_FFFF);
                    else begin
                        x = xq.pop_front();
                        check("xfer_we", 32'(bus.mem_we), 32'(x.we));
                        check("xfer_addr", bus.mem_addr, x.addr);
                        if (x.we) check("xfer_wdata", bus.mem_wdata, x.data);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_b && bus.resp_valid) begin
            if (exp_q.size() == 0)
                check("resp_unexpected", 32'(exp_q.size()), 32'd1);
            else
                check("rdata", bus.resp_rdata, exp_q.pop_front());
        end
    end

    task automatic issue(input bit we, input logic [31:0] a,
                         input logic [31:0] d);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("ready_timeout", 32'(bus.req_ready), 32'd1);
        if (we) ref_mem[a] = d;
        exp_q.push_back(we ? d : ref_rd(a));
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = ~we;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
    endtask

    task automatic access(input bit we, input logic [31:0] a,
                          input logic [31:0] d, input int nhit,
                          input int nmiss, input bit is_hit);
        int lat;
        bit saw;
        issue(we, a, d);
        lat = 0;
        saw = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.mem_req) saw = 1'b1;
        end while (!bus.resp_valid && lat < 500);
        if (!bus.resp_valid) check("resp_timeout", 32'd0, 32'd1);
        if (is_hit) begin
            check("hit_latency", 32'(lat), 32'd2);
            check("hit_no_mem", 32'(saw), 32'd0);
        end
        check("hit_count", hit_count, 32'(nhit));
        check("miss_count", miss_count, 32'(nmiss));
        check("xfer_left", 32'(xq.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          t;
        int          n0;
        int          bad;
        logic [31:0] a0;
        logic [31:0] d0;
        rst_b = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_hits", hit_count, 32'd0);
        check("rst_misses", miss_count, 32'd0);
        rst_b = 1'b1;

        exp_fill(32'h000);
        access(1'b0, 32'h008, 32'h0, 0, 1, 1'b0);
        access(1'b0, 32'h008, 32'h0, 1, 1, 1'b1);
        access(1'b1, 32'h004, 32'hDEAD_BEEF, 2, 1, 1'b1);
        exp_fill(32'h040);
        access(1'b0, 32'h040, 32'h0, 2, 2, 1'b0);
        access(1'b0, 32'h000, 32'h0, 3, 2, 1'b1);
        exp_fill(32'h080);
        access(1'b0, 32'h080, 32'h0, 3, 3, 1'b0);
        exp_wb(32'h000);
        exp_fill(32'h040);
        access(1'b0, 32'h040, 32'h0, 3, 4, 1'b0);
        exp_fill(32'h0C0);
        access(1'b1, 32'h0C4, 32'h0000_1234, 3, 5, 1'b0);
        access(1'b0, 32'h0C4, 32'h0, 4, 5, 1'b1);
        access(1'b0, 32'h0C0, 32'h0, 5, 5, 1'b1);
        access(1'b0, 32'h040, 32'h0, 6, 5, 1'b1);

        // Dirty 0x0C0 line is evicted; the first writeback word is stalled.
        exp_wb(32'h0C0);
        exp_fill(32'h080);
        hold_ack = 1'b1;
        fork
            access(1'b0, 32'h080, 32'h0, 6, 6, 1'b0);
            begin
                t = 0;
                while (!(bus.mem_req && bus.mem_we) && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                a0 = bus.mem_addr;
                d0 = bus.mem_wdata;
                bad = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (bus.mem_addr !== a0 || bus.mem_wdata !== d0 ||
                        bus.req_ready || bus.resp_valid || !bus.mem_req)
                        bad++;
                end
                check("hold_addr", a0, 32'h0C0);
                check("hold_wdata", d0, 32'h0C0);
                check("hold_stable", 32'(bad), 32'd0);
                hold_ack = 1'b0;
            end
        join

        fixed_dly = 3;
        exp_fill(32'h010);
        n0 = n_ack;
        issue(1'b0, 32'h010, 32'h0);
        t = 0;
        while (n_ack < n0 + 1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("fill2_addr", bus.mem_addr, 32'h014);
        check("fill2_req", 32'(bus.mem_req), 32'd1);
        #2 rst_b = 1'b0;
        #1;
        check("abort_mem_req", 32'(bus.mem_req), 32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        repeat (2) @(negedge clk);
        check("abort_hits", hit_count, 32'd0);
        check("abort_misses", miss_count, 32'd0);
        check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        exp_q.delete();
        xq.delete();
        fixed_dly = 0;
        rst_b = 1'b1;
        n0 = n_ack;
        exp_fill(32'h010);
        access(1'b0, 32'h010, 32'h0, 0, 1, 1'b0);
        check("refill_words", 32'(n_ack - n0), 32'd4);

        repeat (3) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/assoc_wb_cache.md
Name: assoc_wb_cache

Overview:
Parametrised N-way set-associative, write-back, write-allocate cache with multi-word lines, true-LRU replacement and valid/ready handshakes on both sides. It sits between the core load/store port and main memory and is the successor to the single-word direct-mapped cache. The memory side is word-serial with an ack handshake, so memory latency is arbitrary rather than fixed. Saturating hit/miss counters are provided for performance measurement.

Parameters:
ADDR_W, 32, byte address width.
DATA_W, 32, word width. Must be 32; byte bits are addr[1:0] and are ignored.
WAYS, 2, associativity. Allowed values: 1, 2, 4.
SETS, 256, number of sets. Power of 2, >=2.
LINE_WORDS, 4, words per line. Power of 2, >=1.
Address split: tag | index (log2 SETS) | word (log2 LINE_WORDS) | byte (2).

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  asynchronous active-low reset
req_valid  in  1  core request present
req_ready  out  1  cache can accept a request; high only in IDLE
req_we  in  1  1=store, 0=load
req_addr  in  ADDR_W  request byte address
req_wdata  in  DATA_W  store data
resp_valid  out  1  one-cycle completion pulse; no backpressure
resp_rdata  out  DATA_W  load data (store: the written word)
mem_req  out  1  memory word transfer request
mem_we  out  1  1=writeback word, 0=fill word
mem_addr  out  ADDR_W  word address, {tag,index,word,2'b00}
mem_wdata  out  DATA_W  writeback data
mem_rdata  in  DATA_W  fill data, valid on mem_ack
mem_ack  in  1  transfer complete this cycle
hit_count  out  32  saturating count of hits
miss_count  out  32  saturating count of misses

Behaviour:
- Reset (async, rst_b=0): all valid, dirty and age bits cleared; FSM to IDLE. req_ready=1, resp_valid=0, resp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counters=0. Data and tag arrays are not cleared. Reset mid-transfer aborts the transfer and drops mem_req in the same instant.
- Accept: when req_valid&&req_ready are both high at edge T, the cache registers addr, we and wdata; the core may change its inputs afterwards.
- FSM states: IDLE -> LOOKUP -> (RESP | WB -> FILL -> RESP | FILL -> RESP) -> IDLE.
- LOOKUP (cycle T+1): tag compare across all ways.
  - Hit: a load returns the word; a store writes the word and sets dirty. resp_valid at T+2. Hit latency is 2 cycles.
  - Miss: the victim is the lowest-index invalid way; otherwise the way with the largest age. If the victim is valid and dirty, go to WB; otherwise go to FILL.
- WB: write out LINE_WORDS words in order 0..LINE_WORDS-1 using the victim tag. mem_req=1, mem_we=1 and mem_addr/mem_wdata stay stable until mem_ack. On ack, advance to the next word. mem_req may stay high across words. After the last ack, go to FILL.
- FILL: request words 0..LINE_WORDS-1 with mem_we=0. Capture mem_rdata into the line on each ack. After the last ack:
  - set tag and valid, and set dirty = req_we;
  - for a store, merge req_wdata into the requested word;
  - go to RESP.
- RESP: resp_valid=1 for one cycle, then IDLE. mem_req=0 outside WB and FILL.
- LRU: each way has a log2(WAYS)-bit age per set. On every hit or fill, the accessed way's age becomes 0. Valid ways with age below its old age are incremented. Invalid ways' ages are don't-care. WAYS=1 has no age state.
- Counters: a hit increments hit_count in LOOKUP; a miss increments miss_count in LOOKUP. Both saturate at 0xFFFFFFFF.
- Simultaneous events: mem_ack while mem_req=0 is ignored. req_valid outside IDLE is ignored (req_ready=0).

Test Plan:
(Bench uses WAYS=2, SETS=4, LINE_WORDS=4, so set 0 covers 0x000, 0x040, 0x080. Memory model holds mem[a]=a, with random 1-5 cycle ack delay.)
- Cold load 0x008 -> 4 fill transfers at addresses 0x000,0x004,0x008,0x00C, no WB; resp_rdata=0x008; miss_count=1.
- Repeat load 0x008 -> resp_valid exactly 2 cycles after accept, data 0x008, no mem_req; hit_count=1.
- Store 0x004=0xDEADBEEF, then load 0x040 (fills way1), then load 0x000 (hit), then load 0x080 -> victim is the 0x040 line (clean), so no WB. Then load 0x040 -> victim is the dirty 0x000 line: WB writes 0x000..0x00C with 0xDEADBEEF at 0x004, then fill 0x040..0x04C.
- Store miss 0x0C4=0x1234 -> fill 0x0C0..0x0CC, then load 0x0C4 returns 0x1234 (hit) and load 0x0C0 returns 0x0C0.
- Assert rst_b=0 during the 2nd fill word -> mem_req=0 immediately, req_ready=1; reload of same address misses (full 4-word fill).
- Hold mem_ack=0 for 20 cycles during WB -> mem_addr and mem_wdata stable, req_ready=0, no resp_valid.
